// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg: shared types and constants for the LEGv8-subset pipeline.
// Revision: 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int          WORD_BYTES        = 4;
  localparam int          INSTRUCT_MEM_SIZE = 1024;
  localparam logic [31:0] NOP               = 32'hD503_201F;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // Word-aligned and the whole word lies inside the ROM; 65-bit math so no wrap.
  function automatic logic in_bounds(input logic [63:0] addr, input logic [64:0] mem_size);
    logic [64:0] last_byte;
    last_byte = {1'b0, addr} + 65'd3;
    return (addr[1:0] == 2'b00) && (last_byte < mem_size);
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// if_id_reg: IF/ID pipeline register with hold (stall) and clear (squash).
// Revision: 1.0
// ----------------------------------------------------------------------------
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   clear,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t ifid_d;
  if_id_t ifid_q;

  // Squash only drops valid; the stale pc/instr are harmless once invalid.
  always_comb begin
    ifid_d = ifid_q;
    if (clear) begin
      ifid_d.valid = 1'b0;
    end else if (!hold) begin
      ifid_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_q <= '0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign q = ifid_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_fetch: PC register, RUN/HALT control and IF/ID capture.
// Revision: 1.0
// ----------------------------------------------------------------------------
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int          MEM_SIZE = INSTRUCT_MEM_SIZE,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fault
);

  localparam logic [64:0] MEM_LIMIT = 65'(MEM_SIZE);

  logic [63:0]  pc_d, pc_q;
  fetch_state_t state_d, state_q;
  logic         fault_d, fault_q;
  logic [63:0]  pc_plus4;
  logic         ifid_hold;
  logic         ifid_clear;
  if_id_t       ifid_in;
  if_id_t       ifid_out;

  assign pc_plus4 = pc_q + 64'd4;
  assign ifid_in  = '{pc: pc_q, instr: imem_instr, valid: 1'b1};

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    fault_d    = fault_q;
    ifid_hold  = 1'b0;
    ifid_clear = 1'b0;
    if (redirect) begin
      ifid_clear = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        fault_d = 1'b1;
        state_d = HALT;
      end else if (!in_bounds(redirect_pc, MEM_LIMIT)) begin
        // Out-of-range target parks fetch; a later good redirect revives it.
        state_d = HALT;
        pc_d    = redirect_pc;
      end else begin
        pc_d    = redirect_pc;
        state_d = RUN;
      end
    end else if (stall) begin
      ifid_hold = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (in_bounds(pc_plus4, MEM_LIMIT)) begin
            pc_d = pc_plus4;
          end else begin
            state_d = HALT;
          end
        end
        HALT: begin
          ifid_clear = 1'b1;
        end
        default: begin
          state_d = HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= RUN;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .hold  (ifid_hold),
    .clear (ifid_clear),
    .d     (ifid_in),
    .q     (ifid_out)
  );

  assign imem_addr   = pc_q;
  assign if_id_pc    = ifid_out.pc;
  assign if_id_instr = ifid_out.instr;
  assign if_id_valid = ifid_out.valid;
  assign halted      = (state_q == HALT);
  assign fault       = fault_q;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instr_fetch: directed self-checking bench for instr_fetch.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        fault;

  int n_checks;
  int n_errors;

  instr_fetch #(
    .MEM_SIZE (1024),
    .RESET_PC (64'd0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fault       (fault)
  );

  // ROM word tags its own address so captured instructions are traceable.
  assign imem_instr = {8'hE0, imem_addr[23:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic do_redirect(input logic [63:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step();
    redirect    = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'd0;

    // Reset state
    step();
    do_reset();
    check("rst_valid", 64'(if_id_valid), 64'd0);
    check("rst_pc",    if_id_pc,         64'd0);
    check("rst_instr", 64'(if_id_instr), 64'd0);
    check("rst_halt",  64'(halted),      64'd0);
    check("rst_fault", 64'(fault),       64'd0);
    check("rst_addr",  imem_addr,        64'd0);

    // Free run: one instruction per cycle from RESET_PC
    for (int k = 0; k < 5; k++) begin
      step();
      check("run_ifpc",  if_id_pc,         64'(4 * k));
      check("run_valid", 64'(if_id_valid), 64'd1);
      check("run_instr", 64'(if_id_instr), 64'(32'hE000_0000 | 32'(4 * k)));
      check("run_addr",  imem_addr,        64'(4 * (k + 1)));
    end

    // Stall three cycles with pc=8
    do_reset();
    step();
    step();
    check("pre_stall_addr", imem_addr, 64'd8);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_addr",  imem_addr,        64'd8);
      check("stall_ifpc",  if_id_pc,         64'd4);
      check("stall_instr", 64'(if_id_instr), 64'h0000_0000_E000_0004);
      check("stall_valid", 64'(if_id_valid), 64'd1);
    end
    stall = 1'b0;
    step();
    check("resume_ifpc0", if_id_pc, 64'd8);
    step();
    check("resume_ifpc1", if_id_pc, 64'd12);

    // Redirect beats stall
    stall = 1'b1;
    do_redirect(64'h40);
    stall = 1'b0;
    check("redir_valid", 64'(if_id_valid), 64'd0);
    check("redir_addr",  imem_addr,        64'h40);
    check("redir_halt",  64'(halted),      64'd0);
    step();
    check("redir_ifpc",  if_id_pc,         64'h40);
    check("redir_vld1",  64'(if_id_valid), 64'd1);
    check("redir_instr", 64'(if_id_instr), 64'h0000_0000_E000_0040);

    // Run off the end of a 1024-byte ROM
    do_redirect(64'd1012);
    step();
    check("end_ifpc0", if_id_pc, 64'd1012);
    step();
    check("end_ifpc1", if_id_pc, 64'd1016);
    check("end_addr1", imem_addr, 64'd1020);
    step();
    check("end_ifpc2",  if_id_pc,         64'd1020);
    check("end_valid2", 64'(if_id_valid), 64'd1);
    check("end_halt2",  64'(halted),      64'd1);
    check("end_addr2",  imem_addr,        64'd1020);
    step();
    check("halt_valid", 64'(if_id_valid), 64'd0);
    check("halt_halt",  64'(halted),      64'd1);
    check("halt_addr",  imem_addr,        64'd1020);
    do_redirect(64'h10);
    check("revive_halt",  64'(halted),      64'd0);
    check("revive_addr",  imem_addr,        64'h10);
    check("revive_valid", 64'(if_id_valid), 64'd0);
    step();
    check("revive_ifpc",  if_id_pc,         64'h10);
    check("revive_vld1",  64'(if_id_valid), 64'd1);

    // Misaligned redirect: sticky fault, pc held (pc is now 0x14)
    do_redirect(64'h22);
    check("mis_fault", 64'(fault),       64'd1);
    check("mis_halt",  64'(halted),      64'd1);
    check("mis_valid", 64'(if_id_valid), 64'd0);
    check("mis_addr",  imem_addr,        64'h14);
    step();
    check("mis_fault2", 64'(fault),     64'd1);
    check("mis_addr2",  imem_addr,      64'h14);
    do_reset();
    check("clr_fault", 64'(fault),  64'd0);
    check("clr_halt",  64'(halted), 64'd0);
    check("clr_addr",  imem_addr,   64'd0);
    step();
    check("clr_ifpc",  if_id_pc,         64'd0);
    check("clr_valid", 64'(if_id_valid), 64'd1);

    // Out-of-bounds aligned targets park fetch without fault
    do_redirect(64'd1024);
    check("oob_halt",  64'(halted),      64'd1);
    check("oob_valid", 64'(if_id_valid), 64'd0);
    check("oob_fault", 64'(fault),       64'd0);
    check("oob_addr",  imem_addr,        64'd1024);
    step();
    check("oob_valid2", 64'(if_id_valid), 64'd0);
    do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_halt",  64'(halted), 64'd1);
    check("wrap_fault", 64'(fault),  64'd0);
    do_redirect(64'd1020);
    check("last_halt", 64'(halted), 64'd0);
    step();
    check("last_ifpc", if_id_pc,    64'd1020);
    check("last_halt2", 64'(halted), 64'd1);
    do_redirect(64'd1021);
    check("odd_halt",  64'(halted),      64'd1);
    check("odd_valid", 64'(if_id_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_instr_fetch
`default_nettype wire
